// File: rtl/iir_pkg.sv
// Shared constants and FSM encoding for the filter output capture block.
package iir_pkg;
    localparam int NB_DEF = 12;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;
endpackage

// File: rtl/capture_fifo.sv
// Sample FIFO with flush and a registered read port; latency 1 on reads.
// Writes at full are accepted only alongside an accepted read; otherwise the caller drops them.
module capture_fifo #(
    parameter int NB    = 12,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_wr_req,
    input  logic [NB-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic          o_wr_acc,
    output logic [NB-1:0] o_rd_data,
    output logic          o_rd_valid,
    output logic [AW:0]   o_level,
    output logic          o_empty,
    output logic          o_full
);
    localparam logic [AW:0] LVL_MAX = (AW+1)'(DEPTH);

    logic [NB-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [NB-1:0] r_rd_data;
    logic          r_rd_valid;
    logic          w_rd_acc;
    logic          w_wr_acc;

    // A flush wins over both ports in the same cycle.
    assign w_rd_acc = i_rd_en && (r_level != '0) && !i_flush;
    assign w_wr_acc = i_wr_req && !i_flush && ((r_level != LVL_MAX) || w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_wr_acc   = w_wr_acc;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_level    = r_level;
    assign o_empty    = (r_level == '0);
    assign o_full     = (r_level == LVL_MAX);
endmodule

// File: rtl/iir_out_capture.sv
// Filter output sink: captures samples into a FIFO, counts them, keeps a checksum, flags done.
// Read latency 1; input stream has no backpressure, samples arriving at a full FIFO are dropped.
module iir_out_capture
    import iir_pkg::*;
#(
    parameter int NB    = NB_DEF,
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int CW    = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vIn,
    input  logic [NB-1:0] dIn,
    input  logic          arm,
    input  logic [CW-1:0] n_target,
    input  logic          rd_en,
    output logic [NB-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [CW-1:0] count,
    output logic [CW-1:0] checksum,
    output logic          busy,
    output logic          done
);
    cap_state_t    r_state;
    cap_state_t    w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_checksum;
    logic [CW-1:0] r_target;
    logic          r_overflow;
    logic          w_sample;
    logic          w_wr_acc;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_dext;

    assign w_sample  = (r_state == CAPTURE) && vIn && !arm;
    assign w_cnt_nxt = r_count + 1'b1;
    assign w_dext    = {{(CW-NB){dIn[NB-1]}}, dIn};

    capture_fifo #(.NB(NB), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (arm),
        .i_wr_req   (w_sample),
        .i_wr_data  (dIn),
        .i_rd_en    (rd_en),
        .o_wr_acc   (w_wr_acc),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_level    (level),
        .o_empty    (empty),
        .o_full     (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero target means free-running capture until the next arm.
    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = CAPTURE;
        end else if (w_sample && (r_target != '0) && (w_cnt_nxt == r_target)) begin
            w_state_nxt = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_checksum <= '0;
            r_target   <= '0;
            r_overflow <= 1'b0;
        end else if (arm) begin
            r_count    <= '0;
            r_checksum <= '0;
            r_target   <= n_target;
            r_overflow <= 1'b0;
        end else if (w_sample) begin
            r_count <= w_cnt_nxt;
            if (w_wr_acc) begin
                r_checksum <= r_checksum + w_dext;
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign overflow = r_overflow;
    assign count    = r_count;
    assign checksum = r_checksum;
    assign busy     = (r_state == CAPTURE);
    assign done     = (r_state == DONE);
endmodule

// File: tb/tb_iir_out_capture.sv
// Directed bench for iir_out_capture; read data is checked by a scoreboard monitor.
module tb_iir_out_capture;
    localparam int NB    = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vIn = 1'b0;
    logic [NB-1:0] dIn = '0;
    logic          arm = 1'b0;
    logic [CW-1:0] n_target = '0;
    logic          rd_en = 1'b0;
    logic [NB-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;
    logic [CW-1:0] count;
    logic [CW-1:0] checksum;
    logic          busy;
    logic          done;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] mon_exp;

    iir_out_capture #(.NB(NB), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .vIn      (vIn),
        .dIn      (dIn),
        .arm      (arm),
        .n_target (n_target),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .level    (level),
        .overflow (overflow),
        .count    (count),
        .checksum (checksum),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected actual=%0h expected=none", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NB-1:0] d);
        vIn = 1'b1;
        dIn = d;
        tick();
        vIn = 1'b0;
    endtask

    task automatic rd_one(input logic [NB-1:0] e);
        rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
        chk("rd_valid_lat", 32'(rd_valid), 1);
    endtask

    task automatic do_arm(input logic [CW-1:0] n);
        arm = 1'b1;
        n_target = n;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_checksum", 32'(checksum), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 0);

        // Normal capture, gaps between samples.
        do_arm(16'd4);
        chk("arm_busy", 32'(busy), 1);
        send(12'h003);
        tick();
        send(12'hFFF);
        tick();
        tick();
        send(12'h064);
        tick();
        chk("n4_not_done", 32'(done), 0);
        send(12'h800);
        chk("n4_done", 32'(done), 1);
        chk("n4_busy", 32'(busy), 0);
        chk("n4_count", 32'(count), 4);
        chk("n4_checksum", 32'(checksum), 32'h0000F866);
        chk("n4_level", 32'(level), 4);
        rd_one(12'h003);
        rd_one(12'hFFF);
        rd_one(12'h064);
        rd_one(12'h800);
        tick();
        chk("n4_empty", 32'(empty), 1);

        // Overflow: 20 back-to-back samples, no reads.
        do_arm(16'd20);
        for (int i = 1; i <= 20; i++) send(NB'(i));
        chk("ovf_level", 32'(level), 16);
        chk("ovf_full", 32'(full), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 20);
        chk("ovf_checksum", 32'(checksum), 136);
        chk("ovf_done", 32'(done), 1);
        for (int i = 1; i <= 16; i++) rd_one(NB'(i));
        tick();
        chk("ovf_empty", 32'(empty), 1);

        // Full FIFO with simultaneous write and read.
        do_arm(16'd0);
        for (int i = 0; i < 16; i++) send(NB'(32 + i));
        chk("sim_full_pre", 32'(full), 1);
        vIn = 1'b1;
        dIn = 12'h007;
        rd_en = 1'b1;
        exp_q.push_back(12'h020);
        tick();
        vIn = 1'b0;
        rd_en = 1'b0;
        chk("sim_level", 32'(level), 16);
        chk("sim_overflow", 32'(overflow), 0);
        chk("sim_rd_valid", 32'(rd_valid), 1);
        for (int i = 1; i < 16; i++) rd_one(NB'(32 + i));
        rd_one(12'h007);
        tick();
        chk("sim_empty", 32'(empty), 1);

        // Read on empty, then arm beats same-cycle write and read.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rd_valid", 32'(rd_valid), 0);
        send(12'h001);
        send(12'h002);
        send(12'h003);
        chk("pri_level_pre", 32'(level), 3);
        arm = 1'b1;
        n_target = 16'd0;
        vIn = 1'b1;
        dIn = 12'h005;
        rd_en = 1'b1;
        tick();
        arm = 1'b0;
        vIn = 1'b0;
        rd_en = 1'b0;
        chk("pri_level", 32'(level), 0);
        chk("pri_count", 32'(count), 0);
        chk("pri_checksum", 32'(checksum), 0);
        chk("pri_rd_valid", 32'(rd_valid), 0);
        chk("pri_busy", 32'(busy), 1);
        chk("pri_empty", 32'(empty), 1);

        // Unlimited mode keeps capturing.
        for (int i = 0; i < 40; i++) send(12'h001);
        chk("unl_busy", 32'(busy), 1);
        chk("unl_done", 32'(done), 0);
        chk("unl_count", 32'(count), 40);
        chk("unl_checksum", 32'(checksum), 16);
        chk("unl_overflow", 32'(overflow), 1);

        // DONE ignores further samples.
        do_arm(16'd2);
        send(12'h005);
        send(12'h006);
        chk("dn_done", 32'(done), 1);
        chk("dn_count", 32'(count), 2);
        chk("dn_checksum", 32'(checksum), 11);
        for (int i = 0; i < 3; i++) send(12'h064);
        chk("dn_count_hold", 32'(count), 2);
        chk("dn_checksum_hold", 32'(checksum), 11);
        chk("dn_level_hold", 32'(level), 2);
        rd_one(12'h005);
        rd_one(12'h006);
        tick();

        // Asynchronous reset in the middle of a capture.
        do_arm(16'd0);
        for (int i = 0; i < 5; i++) send(NB'(9 + i));
        chk("mid_level_pre", 32'(level), 5);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("mid_rd_valid_pre", 32'(rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_checksum", 32'(checksum), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rd_valid", 32'(rd_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
